pwr_main_seq: RTL and testbench

//  Upstream master for the PCH and CPU rail sub-sequencers. Issues the PwrMain

---
 rtl/pwr_main_seq.sv | 208 ++++++++++++++++++++
 tb/tb_pwr_main_seq.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/pwr_main_seq.sv
`default_nettype none
// ============================================================================
// Module      : pwr_main_seq
// Description : Upstream master sequencer for the PCH and CPU rail
//               sub-sequencers. Powers the PCH domain first, then the CPU
//               domain after a fixed delay, and powers down in the reverse
//               order. It enforces PwrGD rise/fall timeouts, latches a fault
//               cause, and releases the sub-sequencers from their fault state
//               with a one-cycle go_out_flt_st_o pulse.
// Ports       : clk              system clock
//               rst              synchronous active-high reset
//               pwr_on_req_i     level system-on request
//               flt_clr_i        operator fault-clear pulse
//               pch_pwrgd_i      PCH sub-sequencer PwrGD
//               pch_pwrflt_i     PCH sub-sequencer PwrFLT
//               cpu_pwrgd_i      CPU sub-sequencer PwrGD
//               cpu_pwrflt_i     CPU sub-sequencer PwrFLT
//               pch_pwrmain_o    PCH domain on request
//               cpu_pwrmain_o    CPU domain on request
//               go_out_flt_st_o  one-cycle fault-release pulse
//               sys_pwrok_o      high only in RUN
//               seq_fault_o      high only in FAULT
//               fault_code_o     latched fault cause (0 outside FAULT)
//               dbg_fsm_o        current state encoding
// Revision    : 1.0 - initial release
// ============================================================================
module pwr_main_seq #(
    parameter int unsigned T_PGD_TMO = 1000,
    parameter int unsigned T_DLY_ON  = 100,
    parameter int unsigned T_OFF_TMO = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pwr_on_req_i,
    input  logic       flt_clr_i,
    input  logic       pch_pwrgd_i,
    input  logic       pch_pwrflt_i,
    input  logic       cpu_pwrgd_i,
    input  logic       cpu_pwrflt_i,
    output logic       pch_pwrmain_o,
    output logic       cpu_pwrmain_o,
    output logic       go_out_flt_st_o,
    output logic       sys_pwrok_o,
    output logic       seq_fault_o,
    output logic [2:0] fault_code_o,
    output logic [2:0] dbg_fsm_o
);

    typedef enum logic [2:0] {
        S_OFF     = 3'd0,
        S_PCH_ON  = 3'd1,
        S_CPU_DLY = 3'd2,
        S_CPU_ON  = 3'd3,
        S_RUN     = 3'd4,
        S_CPU_OFF = 3'd5,
        S_PCH_OFF = 3'd6,
        S_FAULT   = 3'd7
    } state_t;

    localparam logic [2:0] c_FC_PCH_FLT  = 3'd1;
    localparam logic [2:0] c_FC_PCH_TMO  = 3'd2;
    localparam logic [2:0] c_FC_PCH_LOST = 3'd3;
    localparam logic [2:0] c_FC_CPU_TMO  = 3'd4;
    localparam logic [2:0] c_FC_CPU_FLT  = 3'd5;
    localparam logic [2:0] c_FC_CPU_LOST = 3'd6;
    localparam logic [2:0] c_FC_OFF_TMO  = 3'd7;

    // Terminal timer values: the timer reads N-1 on the Nth edge after entry.
    localparam logic [15:0] c_PGD_LAST = 16'(T_PGD_TMO - 1);
    localparam logic [15:0] c_DLY_LAST = 16'(T_DLY_ON  - 1);
    localparam logic [15:0] c_OFF_LAST = 16'(T_OFF_TMO - 1);

    state_t      state_q, state_d;
    logic [15:0] timer_q;
    logic [2:0]  code_d;
    logic        pch_pwrmain_q, cpu_pwrmain_q, go_out_flt_st_q;
    logic        sys_pwrok_q, seq_fault_q;
    logic [2:0]  fault_code_q;

    // Next-state logic. Within each active state: fault, then off request,
    // then forward progress.
    always_comb begin
        state_d = state_q;
        code_d  = fault_code_q;
        case (state_q)
            S_OFF: begin
                if (pwr_on_req_i && !pch_pwrflt_i && !cpu_pwrflt_i)
                    state_d = S_PCH_ON;
            end
            S_FAULT: begin
                if (flt_clr_i && !pwr_on_req_i)
                    state_d = S_OFF;
            end
            default: begin
                // PCH fault is checked first so it wins a simultaneous fault.
                if (pch_pwrflt_i) begin
                    state_d = S_FAULT;
                    code_d  = c_FC_PCH_FLT;
                end else if (cpu_pwrflt_i) begin
                    state_d = S_FAULT;
                    code_d  = c_FC_CPU_FLT;
                end else begin
                    case (state_q)
                        S_PCH_ON: begin
                            if (!pch_pwrgd_i && timer_q == c_PGD_LAST) begin
                                state_d = S_FAULT;
                                code_d  = c_FC_PCH_TMO;
                            end else if (!pwr_on_req_i) begin
                                state_d = S_PCH_OFF;
                            end else if (pch_pwrgd_i) begin
                                state_d = S_CPU_DLY;
                            end
                        end
                        S_CPU_DLY: begin
                            if (!pch_pwrgd_i) begin
                                state_d = S_FAULT;
                                code_d  = c_FC_PCH_LOST;
                            end else if (!pwr_on_req_i) begin
                                state_d = S_PCH_OFF;
                            end else if (timer_q == c_DLY_LAST) begin
                                state_d = S_CPU_ON;
                            end
                        end
                        S_CPU_ON: begin
                            if (!pch_pwrgd_i) begin
                                state_d = S_FAULT;
                                code_d  = c_FC_PCH_LOST;
                            end else if (!cpu_pwrgd_i && timer_q == c_PGD_LAST) begin
                                state_d = S_FAULT;
                                code_d  = c_FC_CPU_TMO;
                            end else if (!pwr_on_req_i) begin
                                state_d = S_CPU_OFF;
                            end else if (cpu_pwrgd_i) begin
                                state_d = S_RUN;
                            end
                        end
                        S_RUN: begin
                            if (!pch_pwrgd_i) begin
                                state_d = S_FAULT;
                                code_d  = c_FC_PCH_LOST;
                            end else if (!cpu_pwrgd_i) begin
                                state_d = S_FAULT;
                                code_d  = c_FC_CPU_LOST;
                            end else if (!pwr_on_req_i) begin
                                state_d = S_CPU_OFF;
                            end
                        end
                        S_CPU_OFF: begin
                            if (cpu_pwrgd_i && timer_q == c_OFF_LAST) begin
                                state_d = S_FAULT;
                                code_d  = c_FC_OFF_TMO;
                            end else if (!cpu_pwrgd_i) begin
                                state_d = S_PCH_OFF;
                            end
                        end
                        S_PCH_OFF: begin
                            // A renewed on request waits until OFF is reached.
                            if (pch_pwrgd_i && timer_q == c_OFF_LAST) begin
                                state_d = S_FAULT;
                                code_d  = c_FC_OFF_TMO;
                            end else if (!pch_pwrgd_i) begin
                                state_d = S_OFF;
                            end
                        end
                        default: state_d = state_q;
                    endcase
                end
            end
        endcase
    end

    // State, timer and Moore outputs; outputs are decoded from state_d so
    // they change on the same edge as the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_OFF;
            timer_q         <= 16'd0;
            pch_pwrmain_q   <= 1'b0;
            cpu_pwrmain_q   <= 1'b0;
            go_out_flt_st_q <= 1'b0;
            sys_pwrok_q     <= 1'b0;
            seq_fault_q     <= 1'b0;
            fault_code_q    <= 3'd0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q)
                timer_q <= 16'd0;
            else if (timer_q != 16'hFFFF)
                timer_q <= timer_q + 16'd1;
            pch_pwrmain_q   <= (state_d inside {S_PCH_ON, S_CPU_DLY, S_CPU_ON, S_RUN, S_CPU_OFF});
            cpu_pwrmain_q   <= (state_d inside {S_CPU_ON, S_RUN});
            sys_pwrok_q     <= (state_d == S_RUN);
            seq_fault_q     <= (state_d == S_FAULT);
            fault_code_q    <= (state_d == S_FAULT) ? code_d : 3'd0;
            go_out_flt_st_q <= (state_q == S_FAULT) && (state_d == S_OFF);
        end
    end

    assign pch_pwrmain_o   = pch_pwrmain_q;
    assign cpu_pwrmain_o   = cpu_pwrmain_q;
    assign go_out_flt_st_o = go_out_flt_st_q;
    assign sys_pwrok_o     = sys_pwrok_q;
    assign seq_fault_o     = seq_fault_q;
    assign fault_code_o    = fault_code_q;
    assign dbg_fsm_o       = state_q;

endmodule
`default_nettype wire

// File: tb/tb_pwr_main_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwr_main_seq
// Description : Self-checking bench for pwr_main_seq. Each step pushes the
//               expected output vector onto a scoreboard, advances one clock
//               and compares the popped entry against the DUT outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwr_main_seq;

    localparam logic [2:0] c_OFF = 3'd0, c_PCH_ON = 3'd1, c_CPU_DLY = 3'd2,
                           c_CPU_ON = 3'd3, c_RUN = 3'd4, c_CPU_OFF = 3'd5,
                           c_PCH_OFF = 3'd6, c_FAULT = 3'd7;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pwr_on_req = 1'b0, flt_clr = 1'b0;
    logic       pch_pwrgd = 1'b0, pch_pwrflt = 1'b0;
    logic       cpu_pwrgd = 1'b0, cpu_pwrflt = 1'b0;
    logic       pch_pwrmain, cpu_pwrmain, go_out_flt_st, sys_pwrok, seq_fault;
    logic [2:0] fault_code, dbg_fsm;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string       tag;
        logic [10:0] v;
    } sb_t;
    sb_t sb[$];

    pwr_main_seq #(
        .T_PGD_TMO (20),
        .T_DLY_ON  (5),
        .T_OFF_TMO (20)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .pwr_on_req_i    (pwr_on_req),
        .flt_clr_i       (flt_clr),
        .pch_pwrgd_i     (pch_pwrgd),
        .pch_pwrflt_i    (pch_pwrflt),
        .cpu_pwrgd_i     (cpu_pwrgd),
        .cpu_pwrflt_i    (cpu_pwrflt),
        .pch_pwrmain_o   (pch_pwrmain),
        .cpu_pwrmain_o   (cpu_pwrmain),
        .go_out_flt_st_o (go_out_flt_st),
        .sys_pwrok_o     (sys_pwrok),
        .seq_fault_o     (seq_fault),
        .fault_code_o    (fault_code),
        .dbg_fsm_o       (dbg_fsm)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Expected vector {dbg, code, go, fault, pwrok, cpu_main, pch_main}
    function automatic logic [10:0] expv(input logic [2:0] st, input logic [2:0] code,
                                         input logic go);
        logic pch, cpu;
        pch = (st == c_PCH_ON) || (st == c_CPU_DLY) || (st == c_CPU_ON) ||
              (st == c_RUN) || (st == c_CPU_OFF);
        cpu = (st == c_CPU_ON) || (st == c_RUN);
        return {st, code, go, (st == c_FAULT), (st == c_RUN), cpu, pch};
    endfunction

    task automatic chk(input string tag, input logic [10:0] obs, input logic [10:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%03h expected=%03h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic [2:0] st, input logic [2:0] code,
                        input logic go);
        sb_t e;
        sb.push_back('{tag, expv(st, code, go)});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk(e.tag, {dbg_fsm, fault_code, go_out_flt_st, seq_fault, sys_pwrok,
                    cpu_pwrmain, pch_pwrmain}, e.v);
    endtask

    task automatic steps(input int n, input string tag, input logic [2:0] st,
                         input logic [2:0] code);
        for (int i = 0; i < n; i++) step(tag, st, code, 1'b0);
    endtask

    // Clear a fault with the request low and both domains off.
    task automatic clear_fault();
        pwr_on_req = 1'b0;
        pch_pwrgd  = 1'b0;
        cpu_pwrgd  = 1'b0;
        pch_pwrflt = 1'b0;
        cpu_pwrflt = 1'b0;
        flt_clr    = 1'b1;
        step("clr_go", c_OFF, 3'd0, 1'b1);
        flt_clr = 1'b0;
        step("clr_off", c_OFF, 3'd0, 1'b0);
    endtask

    task automatic to_cpu_dly();
        pwr_on_req = 1'b1;
        step("pch_on", c_PCH_ON, 3'd0, 1'b0);
        steps(2, "pch_on_wait", c_PCH_ON, 3'd0);
        pch_pwrgd = 1'b1;
        step("cpu_dly", c_CPU_DLY, 3'd0, 1'b0);
    endtask

    task automatic to_run();
        to_cpu_dly();
        steps(4, "cpu_dly_wait", c_CPU_DLY, 3'd0);
        step("cpu_on", c_CPU_ON, 3'd0, 1'b0);
        steps(3, "cpu_on_wait", c_CPU_ON, 3'd0);
        cpu_pwrgd = 1'b1;
        step("run", c_RUN, 3'd0, 1'b0);
    endtask

    initial begin
        step("reset", c_OFF, 3'd0, 1'b0);
        rst = 1'b0;
        step("idle", c_OFF, 3'd0, 1'b0);

        // 1: normal on/off
        to_run();
        pwr_on_req = 1'b0;
        step("cpu_off", c_CPU_OFF, 3'd0, 1'b0);
        steps(2, "cpu_off_wait", c_CPU_OFF, 3'd0);
        cpu_pwrgd = 1'b0;
        step("pch_off", c_PCH_OFF, 3'd0, 1'b0);
        step("pch_off_wait", c_PCH_OFF, 3'd0, 1'b0);
        pch_pwrgd = 1'b0;
        step("off", c_OFF, 3'd0, 1'b0);

        // 2: PCH PwrGD timeout 20 edges after PCH_ON entry
        pwr_on_req = 1'b1;
        step("tmo_pch_on", c_PCH_ON, 3'd0, 1'b0);
        steps(19, "tmo_wait", c_PCH_ON, 3'd0);
        step("pch_tmo", c_FAULT, 3'd2, 1'b0);
        clear_fault();

        // 3: CPU PwrGD lost in RUN, then clear rules
        to_run();
        cpu_pwrgd = 1'b0;
        step("cpu_lost", c_FAULT, 3'd6, 1'b0);
        flt_clr = 1'b1;
        step("clr_ignored", c_FAULT, 3'd6, 1'b0);
        flt_clr = 1'b0;
        pwr_on_req = 1'b0;
        step("fault_hold", c_FAULT, 3'd6, 1'b0);
        clear_fault();

        // 4: simultaneous faults in CPU_ON
        to_run();
        pwr_on_req = 1'b0;
        step("dummy_off", c_CPU_OFF, 3'd0, 1'b0);
        cpu_pwrgd = 1'b0;
        step("dummy_pch_off", c_PCH_OFF, 3'd0, 1'b0);
        pch_pwrgd = 1'b0;
        step("dummy_idle", c_OFF, 3'd0, 1'b0);
        to_cpu_dly();
        steps(4, "cpu_dly_wait", c_CPU_DLY, 3'd0);
        step("cpu_on", c_CPU_ON, 3'd0, 1'b0);
        pch_pwrflt = 1'b1;
        cpu_pwrflt = 1'b1;
        step("dual_flt", c_FAULT, 3'd1, 1'b0);
        clear_fault();

        // 5a: abort during CPU_DLY
        to_cpu_dly();
        step("abort_dly", c_CPU_DLY, 3'd0, 1'b0);
        pwr_on_req = 1'b0;
        step("abort_pch_off", c_PCH_OFF, 3'd0, 1'b0);
        pwr_on_req = 1'b1;
        step("req_ignored", c_PCH_OFF, 3'd0, 1'b0);
        pwr_on_req = 1'b0;
        pch_pwrgd  = 1'b0;
        step("abort_off", c_OFF, 3'd0, 1'b0);

        // 5b: reset while in RUN
        to_run();
        rst = 1'b1;
        step("rst_run", c_OFF, 3'd0, 1'b0);
        pwr_on_req = 1'b0;
        pch_pwrgd  = 1'b0;
        cpu_pwrgd  = 1'b0;
        rst = 1'b0;
        step("post_rst", c_OFF, 3'd0, 1'b0);

        // 6: CPU PwrGD stuck high during power-down
        to_run();
        pwr_on_req = 1'b0;
        step("off_tmo_entry", c_CPU_OFF, 3'd0, 1'b0);
        steps(19, "off_tmo_wait", c_CPU_OFF, 3'd0);
        step("off_tmo", c_FAULT, 3'd7, 1'b0);
        clear_fault();

        if (sb.size() != 0) chk("sb_empty", 11'(sb.size()), 11'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
